lcd_frame_reader: RTL and testbench

- Read-side counterpart of the SDRAM frame-writer path. Generates VGA/LCD raster timing on clk and pulls one 24-bit RGB888 pixel per active pixel clock from the SDRAM controller's read port.
- Drives the panel-side pixel bus.
- Issues a per-frame sys_load pulse so the controller rewinds its read address to the frame base.

---
 rtl/lcd_frame_reader.sv | 99 +++++++++
 tb/tb_lcd_frame_reader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_reader.sv
// rtl/lcd_frame_reader.sv - raster timing generator pulling RGB888 pixels from the SDRAM read port
module lcd_frame_reader #(
  parameter logic [11:0] H_DISP  = 12'd640,
  parameter logic [11:0] H_FRONT = 12'd16,
  parameter logic [11:0] H_SYNC  = 12'd96,
  parameter logic [11:0] H_BACK  = 12'd48,
  parameter logic [11:0] V_DISP  = 12'd480,
  parameter logic [11:0] V_FRONT = 12'd10,
  parameter logic [11:0] V_SYNC  = 12'd2,
  parameter logic [11:0] V_BACK  = 12'd33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sys_vaild,
  input  logic        sys_rempty,
  input  logic [23:0] sys_rdata,
  output logic        sys_rd,
  output logic        sys_load,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [23:0] lcd_rgb,
  output logic [10:0] lcd_xpos,
  output logic [10:0] lcd_ypos,
  output logic        underrun
);

  localparam logic [11:0] H_TOTAL     = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam logic [11:0] V_TOTAL     = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic [11:0] H_ACT_START = H_SYNC + H_BACK;
  localparam logic [11:0] H_ACT_END   = H_SYNC + H_BACK + H_DISP;
  localparam logic [11:0] V_ACT_START = V_SYNC + V_BACK;
  localparam logic [11:0] V_ACT_END   = V_SYNC + V_BACK + V_DISP;
  localparam logic [10:0] H_OFS       = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] V_OFS       = 11'(V_SYNC + V_BACK);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        run;
  logic        hs_n;
  logic        vs_n;
  logic        act;
  logic        rd_ok;

  assign run = rst_n && sys_vaild;

  always_ff @(posedge clk) begin
    if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_TOTAL - 12'd1) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_TOTAL - 12'd1) ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  always_comb begin
    hs_n = !(h_cnt < H_SYNC);
    vs_n = !(v_cnt < V_SYNC);
    act  = (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END) &&
           (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
  end

  // Read strobe and frame rewind are combinational so the data lands one cycle later.
  assign sys_rd   = run && act;
  assign sys_load = run && (h_cnt == 12'd0) && (v_cnt == 12'd0);

  always_ff @(posedge clk) begin
    if (!run) begin
      lcd_de   <= 1'b0;
      lcd_hs   <= 1'b1;
      lcd_vs   <= 1'b1;
      lcd_xpos <= '0;
      lcd_ypos <= '0;
      rd_ok    <= 1'b0;
    end else begin
      lcd_de   <= act;
      lcd_hs   <= hs_n;
      lcd_vs   <= vs_n;
      lcd_xpos <= act ? (h_cnt[10:0] - H_OFS) : 11'd0;
      lcd_ypos <= act ? (v_cnt[10:0] - V_OFS) : 11'd0;
      rd_ok    <= act && !sys_rempty;
    end
  end

  // Underrun survives sys_vaild drops; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underrun <= 1'b0;
    end else if (sys_rd && sys_rempty) begin
      underrun <= 1'b1;
    end
  end

  assign lcd_rgb = (lcd_de && rd_ok) ? sys_rdata : 24'h000000;

endmodule

// File: tb/tb_lcd_frame_reader.sv
// tb/tb_lcd_frame_reader.sv - directed table-driven bench for lcd_frame_reader on a reduced raster
module tb_lcd_frame_reader;

  localparam int FRAME = 165;

  logic        clk;
  logic        rst_n;
  logic        sys_vaild;
  logic        sys_rempty;
  logic [23:0] sys_rdata;
  logic        sys_rd;
  logic        sys_load;
  logic        lcd_hs;
  logic        lcd_vs;
  logic        lcd_de;
  logic [23:0] lcd_rgb;
  logic [10:0] lcd_xpos;
  logic [10:0] lcd_ypos;
  logic        underrun;

  lcd_frame_reader #(
    .H_DISP(12'd8), .H_FRONT(12'd2), .H_SYNC(12'd3), .H_BACK(12'd2),
    .V_DISP(12'd6), .V_FRONT(12'd1), .V_SYNC(12'd2), .V_BACK(12'd2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sys_vaild(sys_vaild), .sys_rempty(sys_rempty),
    .sys_rdata(sys_rdata), .sys_rd(sys_rd), .sys_load(sys_load),
    .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de), .lcd_rgb(lcd_rgb),
    .lcd_xpos(lcd_xpos), .lcd_ypos(lcd_ypos), .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic rd, load, hs, vs, de;
    int   x, y, rgb;
  } vec_t;

  vec_t vec[13];
  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;
  int pix      = 0;
  int empty_cyc = -1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (k=%0d)", name, act, exp, k);
    end
  endtask

  // Advance one clock; feed the pixel counter the cycle after each read.
  task automatic tick();
    logic prev_rd, prev_load;
    prev_rd   = sys_rd;
    prev_load = sys_load;
    @(posedge clk);
    #1;
    if (prev_load) pix = 0;
    if (prev_rd) begin
      pix++;
      sys_rdata = 24'(pix);
    end else begin
      sys_rdata = 24'hA5A5A5;
    end
    k++;
    sys_rempty = (k == empty_cyc);
    #1;
  endtask

  task automatic check_vec(input int rel);
    for (int i = 0; i < 13; i++) begin
      if (vec[i].cyc == rel) begin
        chk($sformatf("v%0d_rd", rel),   sys_rd,   vec[i].rd);
        chk($sformatf("v%0d_load", rel), sys_load, vec[i].load);
        chk($sformatf("v%0d_hs", rel),   lcd_hs,   vec[i].hs);
        chk($sformatf("v%0d_vs", rel),   lcd_vs,   vec[i].vs);
        chk($sformatf("v%0d_de", rel),   lcd_de,   vec[i].de);
        chk($sformatf("v%0d_x", rel),    lcd_xpos, vec[i].x);
        chk($sformatf("v%0d_y", rel),    lcd_ypos, vec[i].y);
        chk($sformatf("v%0d_rgb", rel),  lcd_rgb,  vec[i].rgb);
      end
    end
  endtask

  task automatic run_frame(input bit inj);
    int rd_n, ld_n, hs_n, vs_n, de_n;
    rd_n = 0; ld_n = 0; hs_n = 0; vs_n = 0; de_n = 0;
    if (inj) empty_cyc = k + 98;
    for (int rel = 0; rel < FRAME; rel++) begin
      check_vec(rel);
      if (inj && rel == 98) chk("pre_underrun", underrun, 0);
      if (inj && rel == 99) begin
        chk("ur_rgb", lcd_rgb, 0);
        chk("ur_flag", underrun, 1);
        chk("ur_de", lcd_de, 1);
        chk("ur_x", lcd_xpos, 3);
        chk("ur_y", lcd_ypos, 2);
      end
      if (inj && rel == 100) chk("ur_next_rgb", lcd_rgb, 21);
      rd_n += int'(sys_rd);
      ld_n += int'(sys_load);
      hs_n += int'(!lcd_hs);
      vs_n += int'(!lcd_vs);
      de_n += int'(lcd_de);
      tick();
    end
    chk("reads_per_frame", rd_n, 48);
    chk("loads_per_frame", ld_n, 1);
    chk("hs_low_clocks", hs_n, 33);
    chk("vs_low_clocks", vs_n, 30);
    chk("de_clocks", de_n, 48);
  endtask

  task automatic chk_idle(input string tag, input int ur);
    chk({tag, "_rd"},   sys_rd,   0);
    chk({tag, "_load"}, sys_load, 0);
    chk({tag, "_hs"},   lcd_hs,   1);
    chk({tag, "_vs"},   lcd_vs,   1);
    chk({tag, "_de"},   lcd_de,   0);
    chk({tag, "_rgb"},  lcd_rgb,  0);
    chk({tag, "_x"},    lcd_xpos, 0);
    chk({tag, "_y"},    lcd_ypos, 0);
    chk({tag, "_ur"},   underrun, ur);
  endtask

  initial begin
    //           cyc  rd    load  hs    vs    de    x  y  rgb
    vec[0]  = '{0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0};
    vec[1]  = '{1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vec[2]  = '{3,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
    vec[3]  = '{4,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0};
    vec[4]  = '{30,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0};
    vec[5]  = '{31,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0};
    vec[6]  = '{65,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0};
    vec[7]  = '{66,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 1};
    vec[8]  = '{73,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7, 0, 8};
    vec[9]  = '{74,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0};
    vec[10] = '{81,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1, 9};
    vec[11] = '{148, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7, 5, 48};
    vec[12] = '{149, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0};

    rst_n = 1'b0; sys_vaild = 1'b1; sys_rempty = 1'b0; sys_rdata = 24'h0;
    repeat (3) tick();
    chk_idle("reset", 0);

    sys_vaild = 1'b0; rst_n = 1'b1;
    repeat (2) tick();
    chk_idle("novalid", 0);

    sys_vaild = 1'b1;
    #1;
    k = 0;
    run_frame(1'b0);
    run_frame(1'b1);
    run_frame(1'b0);
    chk("underrun_sticky", underrun, 1);

    repeat (83) tick();
    chk("pre_drop_de", lcd_de, 1);
    chk("pre_drop_x", lcd_xpos, 2);
    chk("pre_drop_y", lcd_ypos, 1);
    chk("pre_drop_rgb", lcd_rgb, 11);
    sys_vaild = 1'b0;
    #1;
    chk("drop_rd_gated", sys_rd, 0);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk_idle("drop", 1);
    end
    sys_vaild = 1'b1;
    #1;
    chk("restore_load", sys_load, 1);
    run_frame(1'b0);

    repeat (83) tick();
    chk("pre_rst_de", lcd_de, 1);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    chk("glitch_de", lcd_de, 1);
    chk("glitch_x", lcd_xpos, 3);
    chk("glitch_y", lcd_ypos, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_sync_de", lcd_de, 1);
    tick();
    chk_idle("midrst", 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_load", sys_load, 1);
    run_frame(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
